// File: rtl/switch_debounce.sv
// Per-channel 2-flop synchronizer plus consecutive-sample debounce counter.
// Optional macro SWITCH_DEBOUNCE_EDGE_EN adds registered rise/fall pulse outputs.
module switch_debounce #(
    parameter int N_CH            = 4,
    parameter int CNT_WIDTH       = 20,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] raw_in,
    output logic [N_CH-1:0] db_out,
    output logic [N_CH-1:0] busy
`ifdef SWITCH_DEBOUNCE_EDGE_EN
    ,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall
`endif
);

    if (DEBOUNCE_CYCLES < 1 || longint'(DEBOUNCE_CYCLES) > (64'd1 << CNT_WIDTH)) begin : g_param_check
        $fatal(1, "switch_debounce: DEBOUNCE_CYCLES must be in 1..2**CNT_WIDTH");
    end

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [N_CH-1:0]                sync1_q, sync2_q;
    logic [N_CH-1:0]                db_q, db_d;
    logic [N_CH-1:0]                flip;
    logic [N_CH-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;

    // A return to the current level at any point restarts the count from zero.
    always_comb begin
        cnt_d = '0;
        db_d  = db_q;
        flip  = '0;
        busy  = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            busy[i] = (cnt_q[i] != '0);
            if (sync2_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                db_d[i]  = sync2_q[i];
                cnt_d[i] = '0;
                flip[i]  = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            db_q    <= '0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_in;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign db_out = db_q;

`ifdef SWITCH_DEBOUNCE_EDGE_EN
    logic [N_CH-1:0] rise_q, fall_q;

    // Pulses are set on the same edge that updates db_q, so they align with the new level.
    always_ff @(posedge clk) begin
        if (rst) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= flip & db_d;
            fall_q <= flip & ~db_d;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;
`endif

endmodule
